// File: rtl/vd_pkg.sv
// Shared definitions for the vd_pipe pipelined adder/subtractor.
package vd_pkg;

   // Operation select encoding on the sub input.
   localparam logic VD_ADD = 1'b0;
   localparam logic VD_SUB = 1'b1;

   // Width of one pipeline slice. Returns 0 when WIDTH cannot be split
   // evenly into STAGES slices (or STAGES < 1), which is an illegal setup.
   function automatic int vd_slice_width(input int width, input int stages);
      if (stages < 1 || (width % stages) != 0) return 0;
      return width / stages;
   endfunction

endpackage

// File: rtl/vd_slice.sv
// Combinational SLICE-bit ripple adder: sum, carry-out and carry into the MSB.
module vd_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             c_i,
   output logic [SLICE-1:0] s_o,
   output logic             c_o,
   output logic             c_msb_o
);

   // Ripple the carry bit by bit, tapping it just before the top bit.
   always_comb begin
      logic c;
      s_o     = '0;
      c       = c_i;
      c_msb_o = c_i;
      for (int i = 0; i < SLICE; i++) begin
         if (i == SLICE - 1) c_msb_o = c;
         s_o[i] = a_i[i] ^ b_i[i] ^ c;
         c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      c_o = c;
   end

endmodule

// File: rtl/vd_pipe.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chained slices.
//
// Handshake: a transfer on either side happens in a cycle where valid and
// ready are both 1 at the rising edge. The whole pipeline advances together
// (adv = !out_valid || out_ready); in_ready equals adv, so a held result
// freezes every stage and blocks new input until the consumer takes it.
module vd_pipe
   import vd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int SLICE = vd_slice_width(WIDTH, STAGES);
   localparam int LAST  = STAGES - 1;

   // Stage registers: operands delayed alongside, partial sum, carry, valid.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             cmsb_q;

   // Values entering each stage (next state for the operand/valid registers).
   logic [WIDTH-1:0] a_d  [STAGES];
   logic [WIDTH-1:0] b_d  [STAGES];
   logic [WIDTH-1:0] s_in [STAGES];
   logic             c_in [STAGES];
   logic             v_d  [STAGES];
   logic [WIDTH-1:0] s_d  [STAGES];

   // Slice adder outputs per stage.
   logic [SLICE-1:0] sl_s [STAGES];
   logic             sl_c [STAGES];
   logic             sl_m [STAGES];

   logic adv;

   assign adv       = !v_q[LAST] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[LAST];
   assign s         = s_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = c_q[LAST] ^ cmsb_q;

   // Stage inputs: stage 0 conditions the operands, later stages take the
   // registers of the stage before them.
   always_comb begin
      a_d[0]  = a;
      b_d[0]  = (sub == VD_SUB) ? ~b : b;
      c_in[0] = (sub == VD_SUB) ? ~cin : cin;
      s_in[0] = '0;
      v_d[0]  = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_d[k]  = a_q[k-1];
         b_d[k]  = b_q[k-1];
         c_in[k] = c_q[k-1];
         s_in[k] = s_q[k-1];
         v_d[k]  = v_q[k-1];
      end
   end

   // One slice adder per stage, each working on its own bit range.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      vd_slice #(.SLICE(SLICE)) u_slice (
         .a_i     (a_d[k][k*SLICE +: SLICE]),
         .b_i     (b_d[k][k*SLICE +: SLICE]),
         .c_i     (c_in[k]),
         .s_o     (sl_s[k]),
         .c_o     (sl_c[k]),
         .c_msb_o (sl_m[k])
      );
   end

   // Merge each stage's new sum slice over the forwarded lower slices.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         s_d[k] = s_in[k];
         s_d[k][k*SLICE +: SLICE] = sl_s[k];
      end
   end

   // Pipeline registers; the last stage only reloads data on a valid result
   // so the outputs stay put across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         cmsb_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_d[k];
            if (k != LAST || v_d[k]) begin
               a_q[k] <= a_d[k];
               b_q[k] <= b_d[k];
               s_q[k] <= s_d[k];
               c_q[k] <= sl_c[k];
            end
         end
         if (v_d[LAST]) cmsb_q <= sl_m[LAST];
      end
   end

endmodule
